// File: rtl/dual_issue_scoreboard.sv
// Register-hazard scoreboard and issue controller for a dual-issue register
// file with separate even and odd write ports. Each register carries a small
// countdown of cycles until its pending write lands, and each write port
// carries a shift vector of reserved write-back slots. Grants are purely
// combinational from the current state and the decoded instruction pair.
module dual_issue_scoreboard #(
    parameter int REG_COUNT      = 128,
    parameter int REG_ADDR_WIDTH = 7,
    parameter int MAX_LAT        = 7,
    parameter int LAT_WIDTH      = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,

    input  logic                      valid_even,
    input  logic [REG_ADDR_WIDTH-1:0] addr_ra_even,
    input  logic [REG_ADDR_WIDTH-1:0] addr_rb_even,
    input  logic [REG_ADDR_WIDTH-1:0] addr_rc_even,
    input  logic                      use_ra_even,
    input  logic                      use_rb_even,
    input  logic                      use_rc_even,
    input  logic [REG_ADDR_WIDTH-1:0] addr_rt_even,
    input  logic                      wr_even,
    input  logic [LAT_WIDTH-1:0]      lat_even,

    input  logic                      valid_odd,
    input  logic [REG_ADDR_WIDTH-1:0] addr_ra_odd,
    input  logic [REG_ADDR_WIDTH-1:0] addr_rb_odd,
    input  logic [REG_ADDR_WIDTH-1:0] addr_rc_odd,
    input  logic                      use_ra_odd,
    input  logic                      use_rb_odd,
    input  logic                      use_rc_odd,
    input  logic [REG_ADDR_WIDTH-1:0] addr_rt_odd,
    input  logic                      wr_odd,
    input  logic [LAT_WIDTH-1:0]      lat_odd,

    output logic                      issue_even,
    output logic                      issue_odd,
    output logic                      stall_even,
    output logic                      stall_odd,
    output logic                      wb_due_even,
    output logic                      wb_due_odd
);

    localparam logic [LAT_WIDTH-1:0] LAT_ONE = LAT_WIDTH'(1);

    // A latency of 0 behaves as 1; anything beyond the deepest pipe is clamped
    // so the reservation mask always lands inside the vector.
    function automatic logic [LAT_WIDTH-1:0] lat_norm(input logic [LAT_WIDTH-1:0] lat);
        if (lat == '0) begin
            return LAT_ONE;
        end
        if (int'(lat) > MAX_LAT) begin
            return LAT_WIDTH'(MAX_LAT);
        end
        return lat;
    endfunction

    // One-hot slot mask: bit i stands for "write completes i+1 cycles from now".
    function automatic logic [MAX_LAT-1:0] slot_mask(input logic [LAT_WIDTH-1:0] lat);
        logic [MAX_LAT-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_LAT; i++) begin
            if (int'(lat) == i + 1) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    // Per-register pending-write countdown; zero means the register is ready.
    logic [LAT_WIDTH-1:0] cnt_q [REG_COUNT];
    logic [LAT_WIDTH-1:0] cnt_d [REG_COUNT];

    // Write-back slot reservations per pipe; bit 0 completes this cycle.
    logic [MAX_LAT-1:0] res_even_q, res_even_d;
    logic [MAX_LAT-1:0] res_odd_q,  res_odd_d;

    // The vectors as they will look after this cycle's shift; a new writer
    // must find its slot free in this view, not in the current one.
    logic [MAX_LAT-1:0] res_even_shift, res_odd_shift;

    logic [LAT_WIDTH-1:0] lat_even_n, lat_odd_n;
    logic [MAX_LAT-1:0]   mask_even, mask_odd;

    logic raw_even, waw_even, port_even, hazard_even;
    logic raw_odd,  waw_odd,  port_odd,  hazard_odd;
    logic intra_raw, intra_waw, in_order_ok;

    assign lat_even_n     = lat_norm(lat_even);
    assign lat_odd_n      = lat_norm(lat_odd);
    assign mask_even      = slot_mask(lat_even_n);
    assign mask_odd       = slot_mask(lat_odd_n);
    assign res_even_shift = res_even_q >> 1;
    assign res_odd_shift  = res_odd_q >> 1;

    // Even-slot hazards against the scoreboard state.
    always_comb begin
        raw_even = (use_ra_even && (cnt_q[addr_ra_even] != '0)) ||
                   (use_rb_even && (cnt_q[addr_rb_even] != '0)) ||
                   (use_rc_even && (cnt_q[addr_rc_even] != '0));
        waw_even  = wr_even && (cnt_q[addr_rt_even] != '0);
        port_even = wr_even && ((res_even_shift & mask_even) != '0);
        hazard_even = raw_even || waw_even || port_even;
    end

    // Odd-slot hazards against the scoreboard state and the issuing even slot.
    always_comb begin
        raw_odd = (use_ra_odd && (cnt_q[addr_ra_odd] != '0)) ||
                  (use_rb_odd && (cnt_q[addr_rb_odd] != '0)) ||
                  (use_rc_odd && (cnt_q[addr_rc_odd] != '0));
        waw_odd  = wr_odd && (cnt_q[addr_rt_odd] != '0);
        port_odd = wr_odd && ((res_odd_shift & mask_odd) != '0);
        intra_raw = issue_even && wr_even &&
                    ((use_ra_odd && (addr_ra_odd == addr_rt_even)) ||
                     (use_rb_odd && (addr_rb_odd == addr_rt_even)) ||
                     (use_rc_odd && (addr_rc_odd == addr_rt_even)));
        intra_waw = issue_even && wr_even && wr_odd && (addr_rt_odd == addr_rt_even);
        hazard_odd = raw_odd || waw_odd || port_odd || intra_raw || intra_waw;
    end

    // The odd slot may only go when the even slot is empty or going too.
    assign in_order_ok = issue_even || !valid_even;

    assign issue_even  = valid_even && !flush && !reset && !hazard_even;
    assign issue_odd   = valid_odd && !flush && !reset && in_order_ok && !hazard_odd;
    assign stall_even  = valid_even && !issue_even;
    assign stall_odd   = valid_odd && !issue_odd;
    assign wb_due_even = res_even_q[0];
    assign wb_due_odd  = res_odd_q[0];

    // Counter next state: decrement pending entries, then let new writers load.
    always_comb begin
        for (int r = 0; r < REG_COUNT; r++) begin
            if (flush) begin
                cnt_d[r] = '0;
            end else if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - LAT_ONE;
            end else begin
                cnt_d[r] = cnt_q[r];
            end
        end
        if (issue_even && wr_even) begin
            cnt_d[addr_rt_even] = lat_even_n;
        end
        if (issue_odd && wr_odd) begin
            cnt_d[addr_rt_odd] = lat_odd_n;
        end
    end

    // Reservation next state: shift toward completion and book the new slot.
    always_comb begin
        res_even_d = res_even_shift;
        res_odd_d  = res_odd_shift;
        if (issue_even && wr_even) begin
            res_even_d = res_even_d | mask_even;
        end
        if (issue_odd && wr_odd) begin
            res_odd_d = res_odd_d | mask_odd;
        end
        if (flush) begin
            res_even_d = '0;
            res_odd_d  = '0;
        end
    end

    // Scoreboard state registers; reset forgets every pending write at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < REG_COUNT; r++) begin
                cnt_q[r] <= '0;
            end
            res_even_q <= '0;
            res_odd_q  <= '0;
        end else begin
            cnt_q      <= cnt_d;
            res_even_q <= res_even_d;
            res_odd_q  <= res_odd_d;
        end
    end

endmodule

// File: tb/tb_dual_issue_scoreboard.sv
// Directed bench for dual_issue_scoreboard: a cycle-by-cycle vector table
// with hand-computed grants and write-back flags, plus hand-written reset
// sequences.
module tb_dual_issue_scoreboard;

    typedef struct packed {
        logic [6:0] ra;
        logic       ua;
        logic [6:0] rb;
        logic       ub;
        logic [6:0] rc;
        logic       uc;
        logic [6:0] rt;
        logic       wr;
        logic [2:0] lat;
    } slot_t;

    typedef struct {
        logic  fl;
        logic  ve;
        slot_t se;
        logic  vo;
        slot_t so;
        logic  ie;
        logic  io;
        logic  we;
        logic  wo;
    } vec_t;

    logic clk = 1'b0;
    logic reset, flush;
    logic valid_even, use_ra_even, use_rb_even, use_rc_even, wr_even;
    logic [6:0] addr_ra_even, addr_rb_even, addr_rc_even, addr_rt_even;
    logic [2:0] lat_even;
    logic valid_odd, use_ra_odd, use_rb_odd, use_rc_odd, wr_odd;
    logic [6:0] addr_ra_odd, addr_rb_odd, addr_rc_odd, addr_rt_odd;
    logic [2:0] lat_odd;
    logic issue_even, issue_odd, stall_even, stall_odd, wb_due_even, wb_due_odd;

    int nchecks = 0;
    int nerrors = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    dual_issue_scoreboard dut (
        .clk(clk), .reset(reset), .flush(flush),
        .valid_even(valid_even),
        .addr_ra_even(addr_ra_even), .addr_rb_even(addr_rb_even), .addr_rc_even(addr_rc_even),
        .use_ra_even(use_ra_even), .use_rb_even(use_rb_even), .use_rc_even(use_rc_even),
        .addr_rt_even(addr_rt_even), .wr_even(wr_even), .lat_even(lat_even),
        .valid_odd(valid_odd),
        .addr_ra_odd(addr_ra_odd), .addr_rb_odd(addr_rb_odd), .addr_rc_odd(addr_rc_odd),
        .use_ra_odd(use_ra_odd), .use_rb_odd(use_rb_odd), .use_rc_odd(use_rc_odd),
        .addr_rt_odd(addr_rt_odd), .wr_odd(wr_odd), .lat_odd(lat_odd),
        .issue_even(issue_even), .issue_odd(issue_odd),
        .stall_even(stall_even), .stall_odd(stall_odd),
        .wb_due_even(wb_due_even), .wb_due_odd(wb_due_odd)
    );

    function automatic slot_t mk(int ra, int ua, int rb, int ub, int rc, int uc,
                                 int rt, int wr, int lat);
        slot_t s;
        s.ra = 7'(ra); s.ua = 1'(ua);
        s.rb = 7'(rb); s.ub = 1'(ub);
        s.rc = 7'(rc); s.uc = 1'(uc);
        s.rt = 7'(rt); s.wr = 1'(wr); s.lat = 3'(lat);
        return s;
    endfunction

    function automatic slot_t NOP();            return mk(0, 0, 0, 0, 0, 0, 0, 0, 1);  endfunction
    function automatic slot_t W(int rt, int l); return mk(0, 0, 0, 0, 0, 0, rt, 1, l); endfunction
    function automatic slot_t RA(int r);        return mk(r, 1, 0, 0, 0, 0, 0, 0, 1);  endfunction
    function automatic slot_t RB(int r);        return mk(0, 0, r, 1, 0, 0, 0, 0, 1);  endfunction
    function automatic slot_t RC(int r);        return mk(0, 0, 0, 0, r, 1, 0, 0, 1);  endfunction

    task automatic addv(input logic fl, input logic ve, input slot_t se,
                        input logic vo, input slot_t so,
                        input logic ie, input logic io, input logic we, input logic wo);
        vec_t v;
        v.fl = fl; v.ve = ve; v.se = se; v.vo = vo; v.so = so;
        v.ie = ie; v.io = io; v.we = we; v.wo = wo;
        vecs.push_back(v);
    endtask

    task automatic idle(input logic we, input logic wo);
        addv(0, 0, NOP(), 0, NOP(), 0, 0, we, wo);
    endtask

    task automatic drive(input logic fl, input logic ve, input slot_t se,
                         input logic vo, input slot_t so);
        flush = fl;
        valid_even = ve;
        addr_ra_even = se.ra; use_ra_even = se.ua;
        addr_rb_even = se.rb; use_rb_even = se.ub;
        addr_rc_even = se.rc; use_rc_even = se.uc;
        addr_rt_even = se.rt; wr_even = se.wr; lat_even = se.lat;
        valid_odd = vo;
        addr_ra_odd = so.ra; use_ra_odd = so.ua;
        addr_rb_odd = so.rb; use_rb_odd = so.ub;
        addr_rc_odd = so.rc; use_rc_odd = so.uc;
        addr_rt_odd = so.rt; wr_odd = so.wr; lat_odd = so.lat;
    endtask

    task automatic chk(input string nm, input int idx, input logic act, input logic exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s step %0d: got %b expected %b", nm, idx, act, exp);
        end
    endtask

    initial begin
        // Cycle-by-cycle table; the scoreboard state carries from row to row.
        // Even writer r5 lat 4, then a reader of r5.
        addv(0, 1, W(5, 4), 0, NOP(), 1, 0, 0, 0);
        addv(0, 1, RA(5),   0, NOP(), 0, 0, 0, 0);
        addv(0, 1, RA(5),   0, NOP(), 0, 0, 0, 0);
        addv(0, 1, RA(5),   0, NOP(), 0, 0, 0, 0);
        addv(0, 1, RA(5),   0, NOP(), 0, 0, 1, 0);
        addv(0, 1, RA(5),   0, NOP(), 1, 0, 0, 0);
        // Pair: even writes r10, odd reads r10.
        addv(0, 1, W(10, 2), 1, RA(10), 1, 0, 0, 0);
        addv(0, 0, NOP(),    1, RA(10), 0, 0, 0, 0);
        addv(0, 0, NOP(),    1, RA(10), 0, 0, 1, 0);
        addv(0, 0, NOP(),    1, RA(10), 0, 1, 0, 0);
        // Even RAW stall (via rb) holds back an independent odd.
        addv(0, 1, W(3, 3), 0, NOP(),  1, 0, 0, 0);
        addv(0, 1, RB(3),   1, RA(4),  0, 0, 0, 0);
        addv(0, 1, RB(3),   1, RA(4),  0, 0, 0, 0);
        addv(0, 1, RB(3),   1, RA(4),  0, 0, 1, 0);
        addv(0, 1, RB(3),   1, RA(4),  1, 1, 0, 0);
        // Even write-port conflict: lat 6 at c0, lat 3 at c3 collides.
        addv(0, 1, W(11, 6), 0, NOP(), 1, 0, 0, 0);
        idle(0, 0);
        idle(0, 0);
        addv(0, 1, W(12, 3), 0, NOP(), 0, 0, 0, 0);
        addv(0, 1, W(12, 3), 0, NOP(), 1, 0, 0, 0);
        idle(0, 0);
        idle(1, 0);
        idle(1, 0);
        idle(0, 0);
        // Both pipes write different registers with equal latency.
        addv(0, 1, W(20, 2), 1, W(21, 2), 1, 1, 0, 0);
        idle(0, 0);
        idle(1, 1);
        idle(0, 0);
        // Intra-pair WAW on r7.
        addv(0, 1, W(7, 2), 1, W(7, 1), 1, 0, 0, 0);
        addv(0, 0, NOP(),   1, W(7, 1), 0, 0, 0, 0);
        addv(0, 0, NOP(),   1, W(7, 1), 0, 0, 1, 0);
        addv(0, 0, NOP(),   1, W(7, 1), 0, 1, 0, 0);
        idle(0, 1);
        idle(0, 0);
        // Latency 0 behaves as 1.
        addv(0, 1, W(30, 0), 0, NOP(), 1, 0, 0, 0);
        addv(0, 1, RA(30),   0, NOP(), 0, 0, 1, 0);
        addv(0, 1, RA(30),   0, NOP(), 1, 0, 0, 0);
        // RAW through rc.
        addv(0, 1, W(40, 1), 0, NOP(), 1, 0, 0, 0);
        addv(0, 1, RC(40),   0, NOP(), 0, 0, 1, 0);
        addv(0, 1, RC(40),   0, NOP(), 1, 0, 0, 0);
        // Unused source is ignored; WAW on a pending destination stalls.
        addv(0, 1, W(41, 3), 0, NOP(), 1, 0, 0, 0);
        addv(0, 1, mk(41, 0, 0, 0, 0, 0, 0, 0, 1), 0, NOP(), 1, 0, 0, 0);
        addv(0, 1, W(41, 1), 0, NOP(), 0, 0, 0, 0);
        addv(0, 1, W(41, 1), 0, NOP(), 0, 0, 1, 0);
        addv(0, 1, W(41, 1), 0, NOP(), 1, 0, 0, 0);
        idle(1, 0);
        idle(0, 0);
        // Flush forgets a pending write and blocks grants in its cycle.
        addv(0, 1, W(50, 5), 0, NOP(),  1, 0, 0, 0);
        addv(1, 1, RA(50),   1, RA(51), 0, 0, 0, 0);
        addv(0, 1, RA(50),   0, NOP(),  1, 0, 0, 0);
        idle(0, 0);
        idle(0, 0);
        idle(0, 0);
        addv(1, 1, W(52, 1), 0, NOP(), 0, 0, 0, 0);
        addv(0, 1, RA(52),   0, NOP(), 1, 0, 0, 0);
        // Odd write-port conflict with the even slot empty.
        addv(0, 0, NOP(), 1, W(60, 4), 0, 1, 0, 0);
        idle(0, 0);
        addv(0, 0, NOP(), 1, W(61, 2), 0, 0, 0, 0);
        addv(0, 0, NOP(), 1, W(61, 2), 0, 1, 0, 0);
        idle(0, 1);
        idle(0, 1);
        idle(0, 0);
        // Non-writing even with rt matching an odd source is no hazard.
        addv(0, 1, mk(0, 0, 0, 0, 0, 0, 70, 0, 1), 1, RC(70), 1, 1, 0, 0);

        // Reset state with a request present.
        reset = 1'b1;
        drive(0, 1, RA(1), 1, RA(2));
        #3;
        chk("reset_issue_even", 0, issue_even, 1'b0);
        chk("reset_issue_odd",  0, issue_odd,  1'b0);
        chk("reset_stall_even", 0, stall_even, 1'b1);
        chk("reset_wb_even",    0, wb_due_even, 1'b0);
        chk("reset_wb_odd",     0, wb_due_odd,  1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].fl, vecs[i].ve, vecs[i].se, vecs[i].vo, vecs[i].so);
            @(negedge clk);
            chk("issue_even",  i, issue_even,  vecs[i].ie);
            chk("issue_odd",   i, issue_odd,   vecs[i].io);
            chk("wb_due_even", i, wb_due_even, vecs[i].we);
            chk("wb_due_odd",  i, wb_due_odd,  vecs[i].wo);
            chk("stall_even",  i, stall_even,  vecs[i].ve & ~vecs[i].ie);
            chk("stall_odd",   i, stall_odd,   vecs[i].vo & ~vecs[i].io);
            @(posedge clk);
            #1;
        end

        // Writer r20 lat 7, then a half-cycle reset pulse in cycle 2.
        drive(0, 1, W(20, 7), 0, NOP());
        @(negedge clk);
        chk("rst_seq_writer", 0, issue_even, 1'b1);
        @(posedge clk);
        #1;
        drive(0, 1, RA(20), 0, NOP());
        @(negedge clk);
        chk("rst_seq_pending", 1, issue_even, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        chk("rst_seq_held", 2, issue_even, 1'b0);
        chk("rst_seq_stall", 2, stall_even, 1'b1);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_seq_cleared", 2, issue_even, 1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_seq_after", 3, issue_even, 1'b1);
        @(posedge clk);
        #1;
        drive(0, 0, NOP(), 0, NOP());
        for (int c = 4; c <= 8; c++) begin
            @(negedge clk);
            chk("rst_seq_no_wb", c, wb_due_even, 1'b0);
            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule

// File: doc/dual_issue_scoreboard.md
# dual_issue_scoreboard

Register-hazard scoreboard and issue controller for the dual-issue SPU register file (REG_COUNT × QUADWORD, two write ports: even and odd). It sits between decode and the register-file read stage. Each cycle it decides whether the even and odd instructions of the current pair may issue. It tracks pending writes per register and reserves per-pipe write-back slots, so that no RAW, WAW or write-port conflict reaches the register file.

## Interface
Parameters:
- REG_COUNT, 128: number of architectural registers.
- REG_ADDR_WIDTH, 7: register address width.
- MAX_LAT, 7: largest execution latency in cycles.
- LAT_WIDTH, 3: width of latency inputs and per-register counters.

Ports (clock and reset first):
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  **asynchronous, active-high reset; clears all state immediately.**
- flush  input  1  synchronous clear of all counters and reservations; grants forced 0 in that cycle.
- valid_even / valid_odd  input  1  instruction present in the even / odd slot.
- addr_ra_even, addr_rb_even, addr_rc_even  input  REG_ADDR_WIDTH  even source addresses.
- use_ra_even, use_rb_even, use_rc_even  input  1  even source actually read.
- addr_rt_even  input  REG_ADDR_WIDTH  even destination.
- wr_even  input  1  even instruction writes rt.
- lat_even  input  LAT_WIDTH  even latency, 1..MAX_LAT.
- The odd slot has the same set of ports with the _odd suffix.
- issue_even / issue_odd  output  1  grant, combinational in the same cycle.
- stall_even / stall_odd  output  1  equal to valid & ~issue for that slot.
- wb_due_even / wb_due_odd  output  1  a reserved write on that pipe completes at the end of this cycle.

## Operation
Per-register state:
- Counter cnt[r] of LAT_WIDTH bits. 0 means ready; nonzero means a write is pending.
- Every cycle, each nonzero cnt decrements by 1.
- An issuing writer loads cnt[rt] <= lat. The load wins over the decrement for the same register.

Per-pipe write-back reservations:
- Each pipe has a shift vector res[1..MAX_LAT].
- Every cycle the vector shifts toward index 1; res[1] is dropped.
- An issuing writer with latency L sets res[L] after the shift.
- wb_due = res[1].

Latency rule: lat = 0 is treated as 1. Values above MAX_LAT cannot occur at the default width.

issue_even = valid_even & ~flush & no stall condition. Even stall conditions:
- Any used source has cnt != 0 (RAW).
- wr_even and cnt[rt_even] != 0 (WAW).
- wr_even and res_even[lat_even] = 1 (write-port conflict).

issue_odd = valid_odd & ~flush & (issue_even | ~valid_even) & no stall condition. Odd stall conditions:
- The same three checks on the odd pipe's own state.
- Intra-pair RAW: issue_even & wr_even & a used odd source == rt_even.
- Intra-pair WAW: issue_even & wr_even & wr_odd & rt_odd == rt_even.
- The odd slot never issues ahead of a valid, stalled even slot (in-order issue).

General rules:
- Non-writing instructions (wr = 0) touch no counters or reservations.
- Both pipes writing different registers in the same cycle is legal; each uses its own reservation vector.
- The scoreboard does not perform writes. The pipes assert the register-file write enable when wb_due is high.

## Timing
- Reset values: all cnt = 0; all res = 0; issue_* = 0 while reset is high; wb_due_* = 0.
- Grants are combinational from the inputs and the current state. The state update happens at the next posedge.
- For a writer granted in cycle c with latency L:
  - cnt[rt] = L in cycle c+1 and decrements to 1 in cycle c+L.
  - A dependent instruction can be granted no earlier than cycle c+L+1.
  - wb_due is high in cycle c+L only.
- Reset or flush mid-operation: all pending writes are forgotten. The next cycle, all registers are ready and all slots are free.
- Flush and a valid request in the same cycle: no grant, and the state is cleared.
- Back-to-back writers to the same rt: the second stalls until cnt = 0.

## Test plan
- Reset, then even writes r5 with lat 4 in cycle 0, then even reads r5 → stalled in cycles 1–4, granted in cycle 5; wb_due_even high only in cycle 4.
- Same-cycle pair, even writes r10, odd reads r10 → issue_even = 1, issue_odd = 0; odd is granted in the cycle after cnt[r10] reaches 0.
- Even stalled on RAW with an independent valid odd → both stall (in-order); both are granted the cycle the hazard clears.
- Even-pipe writer lat 6 in cycle 0, then even writer lat 3 in cycle 3 → write-port conflict, stall; lat 3 is granted in cycle 4 (slot 3 is free after the shift).
- Pair writing r7 (even) and r7 (odd) → odd stalls on intra-pair WAW; odd is granted once cnt[r7] reaches 0.
- Writer to r20 with lat 7, then reset pulsed for half a cycle at cycle 2 → cnt and res cleared immediately; a reader of r20 is granted in the first cycle after reset.
